mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares the single-port data/instruction memory between three requesters: instruction fetch (0), core load/store (1) and the crypto accelerator (2). It sits between the PROCESSOR datapath and the memory macro. It serialises accesses, supports a bounded bus lock for atomic crypto bursts, and aborts stalled accesses with a timeout error so that a hung memory cannot freeze the core.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max BUSY cycles waiting for mem_ready (≥2)
- MAX_LOCK, 4, max consecutive locked grants to one requester (≥1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared immediately
- req  in  3  per-requester request; held until gnt
- we  in  3  per-requester write enable
- lock  in  3  per-requester lock request
- addr  in  3*AW  requester i at [i*AW +: AW]
- wdata  in  3*DW  requester i at [i*DW +: DW]
- gnt  out  3  one-hot acceptance pulse (combinational)
- done  out  3  one-hot completion pulse (registered)
- err  out  1  qualifies done: 1 = timed out
- rdata  out  DW  read data, valid with done
- busy  out  1  1 while in BUSY
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, sampled with mem_ready
- mem_ready  in  1  memory completion

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - Pick the winner among asserted req, round-robin starting at last+1 mod 3. last resets to 2, so order after reset is 0,1,2.
  - Lock override: if lock_own is set, only requester `last` is eligible while its req is high. If that req is low, fall back to normal round-robin and clear lock_own.
  - On a win: gnt[w]=1 that cycle. Latch addr/we/wdata of w, set owner=w and last=w, clear tcnt, go to BUSY.
  - No req: stay in IDLE; gnt=0.
- BUSY:
  - mem_en=1; mem_we/mem_addr/mem_wdata are driven from the latches and held stable.
  - Each cycle without mem_ready: tcnt++.
  - mem_ready=1: register rdata=mem_rdata (writes also capture mem_rdata; requesters ignore it). Pulse done[owner] next cycle, err=0, go to IDLE.
  - tcnt==TIMEOUT-1 with no mem_ready: abort. Pulse done[owner] with err=1, rdata=0, go to IDLE. A mem_ready arriving in that same cycle wins (normal completion).
- Lock accounting, evaluated at completion, normal or error:
  - If lock[owner]=1 and lcnt<MAX_LOCK-1: set lock_own, lcnt++.
  - Otherwise: clear lock_own and lcnt. The next arbitration is therefore unrestricted, which guarantees no starvation.
  - An error completion always clears lock_own.
- Outside BUSY: mem_en=0; mem_addr/mem_wdata/mem_we are 0.
- Reset values: state=IDLE, last=2, owner=0, tcnt=0, lcnt=0, lock_own=0, gnt=0, done=0, err=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-BUSY: the access is dropped, no done is issued, and mem_en falls asynchronously.

## Timing
- Request accepted in cycle n (IDLE, gnt high).
- mem_en high from cycle n+1.
- mem_ready in cycle n+k (k≥1) → done in cycle n+k+1, in which the FSM is IDLE and may issue the next gnt.
- Minimum req-to-done latency is 2 cycles; peak throughput is one access per 2 cycles.
- Timeout: done/err in cycle n+TIMEOUT+1 when mem_ready never rises.
- gnt depends combinationally on req/lock/state; done, err and rdata are registered.
- Requesters must hold req/addr/we/wdata stable until gnt. Deasserting req before gnt withdraws the request without side effects.

## Test plan
- Reset then single read: req[1]=1, addr=0x100, mem_ready one cycle after mem_en, mem_rdata=0xDEADBEEF → gnt[1] in cycle 0, done[1] in cycle 2, rdata=0xDEADBEEF, err=0.
- Round-robin fairness: req=3'b111 held with mem_ready always 1 → gnt sequence 0,1,2,0,1,2, one grant every 2 cycles.
- Lock bound: req=3'b111, lock[2]=1, MAX_LOCK=4, starting with last=1 → four consecutive grants to 2, then 0, then 1, then 2.
- Timeout: req[0], mem_ready held 0, TIMEOUT=16 → mem_en high 16 cycles, done[0]=1, err=1, rdata=0. Next req[1] is granted normally.
- Write path: req[1]=1, we[1]=1, addr=0x200, wdata=0x12345678, mem_ready after 3 cycles → mem_we=1 and mem_addr/mem_wdata stable all 3 BUSY cycles, done[1] after.
- Reset mid-access: assert reset in the 2nd BUSY cycle → mem_en=0 immediately, no done pulse, and the first post-reset grant goes to requester 0 when req=3'b111.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bundle: three requester ports plus the memory macro side.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [2:0]      req;
    logic [2:0]      we;
    logic [2:0]      lock;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ready;

    modport slave (
        input  req, we, lock, addr, wdata,
        input  mem_rdata, mem_ready,
        output gnt, done, err, rdata, busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, lock, addr, wdata,
        output mem_rdata, mem_ready,
        input  gnt, done, err, rdata, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single-port memory: fetch (0), load/store (1), crypto (2).
// Supports bounded lock bursts and aborts stalled accesses after TIMEOUT busy cycles.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TIMEOUT  = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] L_LAST = LW'(MAX_LOCK - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    last;
    logic [1:0]    owner;
    logic [1:0]    nxt1;
    logic [1:0]    nxt2;
    logic [1:0]    win;
    logic          win_ok;
    logic          hold;
    logic          take;
    logic          fin_ok;
    logic          fin_to;
    logic [TW-1:0] tcnt;
    logic [LW-1:0] lcnt;
    logic          lock_own;
    logic [AW-1:0] l_addr;
    logic          l_we;
    logic [DW-1:0] l_wdata;
    logic [2:0]    done_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Lock holder keeps the bus only while it keeps requesting.
    always_comb begin
        nxt1   = inc3(last);
        nxt2   = inc3(nxt1);
        hold   = lock_own & bus.req[last];
        win_ok = |bus.req;
        win    = last;
        if (hold)
            win = last;
        else if (bus.req[nxt1])
            win = nxt1;
        else if (bus.req[nxt2])
            win = nxt2;
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        fin_ok   = 1'b0;
        fin_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_ok) begin
                    take     = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    fin_ok   = 1'b1;
                    state_nx = IDLE;
                end else if (tcnt == T_LAST) begin
                    fin_to   = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last     <= 2'd2;
            owner    <= 2'd0;
            tcnt     <= '0;
            lcnt     <= '0;
            lock_own <= 1'b0;
            l_addr   <= '0;
            l_we     <= 1'b0;
            l_wdata  <= '0;
            done_q   <= 3'b000;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done_q <= 3'b000;
            err_q  <= 1'b0;
            if (take) begin
                owner   <= win;
                last    <= win;
                tcnt    <= '0;
                l_addr  <= bus.addr[win*AW +: AW];
                l_we    <= bus.we[win];
                l_wdata <= bus.wdata[win*DW +: DW];
            end
            if (state == IDLE && lock_own && !bus.req[last])
                lock_own <= 1'b0;
            if (state == BUSY) begin
                if (fin_ok || fin_to) begin
                    done_q  <= 3'b001 << owner;
                    err_q   <= fin_to;
                    rdata_q <= fin_ok ? bus.mem_rdata : '0;
                    // Lock chain grows only on clean completions below the bound.
                    if (fin_ok && bus.lock[owner] && lcnt < L_LAST) begin
                        lock_own <= 1'b1;
                        lcnt     <= lcnt + LW'(1);
                    end else begin
                        lock_own <= 1'b0;
                        lcnt     <= '0;
                    end
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

    assign bus.gnt       = (take && !reset) ? (3'b001 << win) : 3'b000;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state == BUSY);
    assign bus.mem_en    = (state == BUSY);
    assign bus.mem_we    = (state == BUSY) && l_we;
    assign bus.mem_addr  = (state == BUSY) ? l_addr : '0;
    assign bus.mem_wdata = (state == BUSY) ? l_wdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 16;
    localparam int MAX_LOCK = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, timed by cycle numbers.
    bit            m_busy;
    int            m_last;
    int            m_owner;
    int            m_start;
    int            m_chain;
    bit            m_lock_own;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [2:0]    e_done;
    logic          e_err;
    logic [DW-1:0] e_rdata;
    int            ncyc;
    int            mw;

    function automatic int pick(input logic [2:0] r);
        if (m_lock_own && r[m_last])
            return m_last;
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (m_last + k) % 3;
            if (r[i])
                return i;
        end
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_last = 2; m_owner = 0;
            m_lock_own = 0; m_chain = 0;
            e_done = 0; e_err = 0; e_rdata = 0;
            ncyc = 0;
        end else begin
            ncyc++;
            e_done = 0;
            e_err = 0;
            if (!m_busy) begin
                mw = pick(bus.req);
                if (m_lock_own && !bus.req[m_last])
                    m_lock_own = 0;
                if (mw >= 0) begin
                    m_busy = 1; m_owner = mw; m_last = mw;
                    m_addr = bus.addr[mw*AW +: AW];
                    m_we = bus.we[mw];
                    m_wdata = bus.wdata[mw*DW +: DW];
                    m_start = ncyc;
                end
            end else if (bus.mem_ready || ncyc - m_start >= TIMEOUT) begin
                e_done = 3'b001 << m_owner;
                e_err = !bus.mem_ready;
                e_rdata = bus.mem_ready ? bus.mem_rdata : '0;
                if (bus.mem_ready && bus.lock[m_owner] && m_chain + 1 < MAX_LOCK) begin
                    m_lock_own = 1;
                    m_chain++;
                end else begin
                    m_lock_own = 0;
                    m_chain = 0;
                end
                m_busy = 0;
            end
        end
    end

    // Event logs and per-cycle comparison against the model.
    int         gq_who[$];
    int         gq_cyc[$];
    int         dq_who[$];
    int         dq_cyc[$];
    logic       dq_err[$];
    logic [DW-1:0] dq_rd[$];
    int         mcyc = 0;
    int         en_cnt = 0;
    int         wr_cnt = 0;
    logic [2:0] g_seen = 3'b000;
    logic [2:0] exp_g;
    int         pw;

    always @(negedge clock) begin
        mcyc++;
        if (!reset) begin
            pw = pick(bus.req);
            exp_g = (!m_busy && pw >= 0) ? (3'b001 << pw) : 3'b000;
            check("gnt", bus.gnt, exp_g);
            check("busy", bus.busy, m_busy);
            check("mem_en", bus.mem_en, m_busy);
            check("mem_we", bus.mem_we, m_busy && m_we);
            check("mem_addr", bus.mem_addr, m_busy ? m_addr : '0);
            check("mem_wdata", bus.mem_wdata, m_busy ? m_wdata : '0);
            check("done", bus.done, e_done);
            check("err", bus.err, e_err);
            if (e_done != 0)
                check("rdata", bus.rdata, e_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.gnt[i]) begin
                gq_who.push_back(i);
                gq_cyc.push_back(mcyc);
            end
            if (bus.done[i]) begin
                dq_who.push_back(i);
                dq_cyc.push_back(mcyc);
                dq_err.push_back(bus.err);
                dq_rd.push_back(bus.rdata);
            end
        end
        g_seen = bus.gnt;
        if (bus.mem_en)
            en_cnt++;
        if (bus.mem_en && bus.mem_we && bus.mem_addr == 32'h200 &&
            bus.mem_wdata == 32'h12345678)
            wr_cnt++;
    end

    // Stimulus control.
    int mem_mode = 0;
    int mem_dly = 1;
    int bc = 0;
    bit keep = 0;
    bit rnd = 0;
    bit rd_rand = 1;

    task automatic tick();
        @(posedge clock);
        #1;
        bc = bus.mem_en ? bc + 1 : 0;
        case (mem_mode)
            0: bus.mem_ready = 1'b1;
            1: bus.mem_ready = (bc == mem_dly);
            2: bus.mem_ready = 1'b0;
            default: bus.mem_ready = ($urandom % 3 == 0);
        endcase
        if (rd_rand)
            bus.mem_rdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            if (g_seen[i] && !keep)
                bus.req[i] = 1'b0;
            if (rnd) begin
                if (!bus.req[i] && $urandom % 4 == 0) begin
                    bus.req[i] = 1'b1;
                    bus.we[i] = 1'($urandom);
                    bus.addr[i*AW +: AW] = $urandom;
                    bus.wdata[i*DW +: DW] = $urandom;
                end else if (bus.req[i] && !g_seen[i] && $urandom % 20 == 0) begin
                    bus.req[i] = 1'b0;
                end
                if ($urandom % 8 == 0)
                    bus.lock[i] = 1'($urandom);
            end
        end
    endtask

    task automatic clear_logs();
        gq_who.delete(); gq_cyc.delete();
        dq_who.delete(); dq_cyc.delete();
        dq_err.delete(); dq_rd.delete();
        en_cnt = 0;
        wr_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 3'b111;
        #1;
        check("rst_gnt", bus.gnt, 3'b000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_en", bus.mem_en, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_done", bus.done, 3'b000);
        check("rst_err", bus.err, 1'b0);
        check("rst_rdata", bus.rdata, 0);
        @(posedge clock);
        #1;
        bus.req = 3'b000;
        bus.we = 3'b000;
        bus.lock = 3'b000;
        keep = 0;
        rnd = 0;
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        bus.req = 0; bus.we = 0; bus.lock = 0;
        bus.addr = '0; bus.wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        do_reset();

        // Single read
        rd_rand = 0;
        bus.mem_rdata = 32'hDEADBEEF;
        mem_mode = 1; mem_dly = 1;
        bus.addr[AW +: AW] = 32'h100;
        bus.req[1] = 1'b1;
        repeat (6) tick();
        check("rd_ngnt", gq_who.size(), 1);
        check("rd_ndone", dq_who.size(), 1);
        if (gq_who.size() == 1 && dq_who.size() == 1) begin
            check("rd_who", gq_who[0], 1);
            check("rd_dwho", dq_who[0], 1);
            check("rd_lat", dq_cyc[0] - gq_cyc[0], 2);
            check("rd_data", dq_rd[0], 32'hDEADBEEF);
            check("rd_err", dq_err[0], 1'b0);
        end
        rd_rand = 1;

        // Round-robin fairness
        do_reset();
        mem_mode = 0; keep = 1;
        bus.req = 3'b111;
        repeat (13) tick();
        check("rr_cnt", gq_who.size() >= 6, 1'b1);
        if (gq_who.size() >= 6)
            for (int i = 0; i < 6; i++) begin
                check("rr_who", gq_who[i], i % 3);
                if (i > 0)
                    check("rr_gap", gq_cyc[i] - gq_cyc[i-1], 2);
            end

        // Lock bound
        do_reset();
        mem_mode = 0; keep = 1;
        bus.lock = 3'b100;
        bus.req = 3'b111;
        repeat (20) tick();
        begin
            int exp_seq[9] = '{0, 1, 2, 2, 2, 2, 0, 1, 2};
            check("lk_cnt", gq_who.size() >= 9, 1'b1);
            if (gq_who.size() >= 9)
                for (int i = 0; i < 9; i++)
                    check("lk_who", gq_who[i], exp_seq[i]);
        end

        // Timeout, then a normal access
        do_reset();
        mem_mode = 2;
        bus.req[0] = 1'b1;
        repeat (TIMEOUT + 4) tick();
        check("to_en", en_cnt, TIMEOUT);
        check("to_ndone", dq_who.size(), 1);
        if (dq_who.size() == 1 && gq_who.size() >= 1) begin
            check("to_who", dq_who[0], 0);
            check("to_err", dq_err[0], 1'b1);
            check("to_rdata", dq_rd[0], 0);
            check("to_lat", dq_cyc[0] - gq_cyc[0], TIMEOUT + 1);
        end
        mem_mode = 0;
        bus.req[1] = 1'b1;
        repeat (5) tick();
        check("to_next_n", dq_who.size(), 2);
        if (dq_who.size() == 2 && gq_who.size() == 2) begin
            check("to_next_who", gq_who[1], 1);
            check("to_next_err", dq_err[1], 1'b0);
        end

        // Write path
        clear_logs();
        mem_mode = 1; mem_dly = 3;
        bus.we[1] = 1'b1;
        bus.addr[AW +: AW] = 32'h200;
        bus.wdata[DW +: DW] = 32'h12345678;
        bus.req[1] = 1'b1;
        repeat (8) tick();
        check("wr_stable", wr_cnt, 3);
        check("wr_ndone", dq_who.size(), 1);
        if (dq_who.size() == 1 && gq_who.size() == 1) begin
            check("wr_who", dq_who[0], 1);
            check("wr_err", dq_err[0], 1'b0);
            check("wr_lat", dq_cyc[0] - gq_cyc[0], 4);
        end
        bus.we = 3'b000;

        // Reset in the middle of an access
        do_reset();
        mem_mode = 2;
        bus.req = 3'b111;
        tick();
        tick();
        check("mr_en_before", bus.mem_en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_en_async", bus.mem_en, 1'b0);
        check("mr_busy_async", bus.busy, 1'b0);
        tick();
        tick();
        check("mr_nodone", dq_who.size(), 0);
        reset = 1'b0;
        clear_logs();
        mem_mode = 0; keep = 1;
        bus.req = 3'b111;
        repeat (4) tick();
        check("mr_first_n", gq_who.size() >= 1, 1'b1);
        if (gq_who.size() >= 1)
            check("mr_first", gq_who[0], 0);

        // Randomized traffic against the model
        do_reset();
        rnd = 1;
        for (int p = 0; p < 15; p++) begin
            case (p % 5)
                3: begin mem_mode = 1; mem_dly = 1 + int'($urandom % 4); end
                4: mem_mode = 2;
                default: mem_mode = 3;
            endcase
            repeat (200) tick();
        end
        check("rnd_activity", dq_who.size() > 50, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
